// File: rtl/cadence_pkg.sv
// Shared types and constants for the cadence period meter: FSM state encoding,
// real/fast-sim timing constants and the slice-and-clip helper.
package cadence_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } cad_state_t;

    // 1/3 s at the real clock, and a shortened value for fast simulation
    localparam logic [23:0] CAD_TIMEOUT_REAL   = 24'hE4E1C0;
    localparam logic [23:0] CAD_TIMEOUT_FAST   = 24'h007271;
    localparam int          CAD_SLICE_LSB_REAL = 16;
    localparam int          CAD_SLICE_LSB_FAST = 7;
    localparam logic [23:0] CAD_MIN_PER        = 24'h000400;

    // Shift the count down to the reported slice and clip to the output width
    function automatic logic [31:0] cad_sat(input logic [31:0] count,
                                           input int          slice_lsb,
                                           input int          per_w);
        logic [31:0] sliced;
        logic [31:0] max_v;
        sliced = count >> slice_lsb;
        max_v  = (per_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << per_w) - 32'd1);
        return (sliced > max_v) ? max_v : sliced;
    endfunction

endpackage

// File: rtl/cadence_avg_window.sv
// Moving-average window over the last 2^AVG_LOG2 period samples, kept as a
// slot shift register plus a running sum so the average never needs an adder tree.
module cadence_avg_window
    import cadence_pkg::*;
#(
    parameter int               PER_W    = 8,
    parameter int               AVG_LOG2 = 2,
    parameter logic [PER_W-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             preload,
    input  logic             shift,
    input  logic [PER_W-1:0] sample,
    output logic [PER_W-1:0] avg
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = PER_W + AVG_LOG2;

    logic [PER_W-1:0] slot_p0 [N];
    logic [SUM_W-1:0] sum_p0;

    // ---- stage p0: window slots and running sum ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) slot_p0[i] <= RST_VAL;
            sum_p0 <= SUM_W'(RST_VAL) << AVG_LOG2;
        end else if (preload) begin
            for (int i = 0; i < N; i++) slot_p0[i] <= sample;
            sum_p0 <= SUM_W'(sample) << AVG_LOG2;
        end else if (shift) begin
            slot_p0[0] <= sample;
            for (int i = 1; i < N; i++) slot_p0[i] <= slot_p0[i-1];
            // Modular arithmetic: the true sum always fits SUM_W, so wrap is harmless
            sum_p0 <= sum_p0 + SUM_W'(sample) - SUM_W'(slot_p0[N-1]);
        end
    end

    assign avg = sum_p0[AVG_LOG2 +: PER_W];

endmodule

// File: rtl/cadence_period_avg.sv
// Pedal-cadence period meter: registered rise detect, saturating period counter,
// STOPPED/ARMED/RUNNING FSM with glitch rejection, and a moving-average output.
module cadence_period_avg
    import cadence_pkg::*;
#(
    parameter int               CNT_W     = 24,
    parameter int               PER_W     = 8,
    parameter int               SLICE_LSB = CAD_SLICE_LSB_REAL,
    parameter logic [CNT_W-1:0] TIMEOUT   = CAD_TIMEOUT_REAL,
    parameter logic [CNT_W-1:0] MIN_PER   = CAD_MIN_PER,
    parameter int               AVG_LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cadence_filt,
    output logic [PER_W-1:0] cadence_per,
    output logic [PER_W-1:0] cadence_avg,
    output logic             per_vld,
    output logic             not_pedaling,
    output logic             glitch
);

    function automatic logic [PER_W-1:0] slice_sat(input logic [CNT_W-1:0] c);
        return PER_W'(cad_sat(32'(c), SLICE_LSB, PER_W));
    endfunction

    localparam logic [PER_W-1:0] SAT_TO = slice_sat(TIMEOUT);

    logic             prev_p0;
    logic             rise_p1;
    cad_state_t       state, state_n;
    logic [CNT_W-1:0] count, count_n, count_inc;
    logic [PER_W-1:0] per_n;
    logic [PER_W-1:0] win_sample;
    logic             per_vld_n, glitch_n;
    logic             win_preload, win_shift;
    logic             accept;

    // ---- stage p0/p1: input history and registered rise ----
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p0 <= 1'b0;
            rise_p1 <= 1'b0;
        end else begin
            prev_p0 <= cadence_filt;
            rise_p1 <= cadence_filt & ~prev_p0;
        end
    end

    assign count_inc = (count == TIMEOUT) ? count : count + CNT_W'(1);
    assign accept    = rise_p1 && (count >= MIN_PER);

    // A rise always beats a simultaneous timeout, so rise_p1 is tested first
    always_comb begin
        state_n     = state;
        count_n     = count_inc;
        per_n       = cadence_per;
        per_vld_n   = 1'b0;
        glitch_n    = 1'b0;
        win_preload = 1'b0;
        win_shift   = 1'b0;
        win_sample  = slice_sat(count);
        unique case (state)
            STOPPED: begin
                count_n = '0;
                if (rise_p1) begin
                    state_n = ARMED;
                    count_n = CNT_W'(1);
                end
            end
            ARMED, RUNNING: begin
                if (accept) begin
                    state_n   = RUNNING;
                    count_n   = CNT_W'(1);
                    per_n     = slice_sat(count);
                    per_vld_n = 1'b1;
                    if (state == ARMED) win_preload = 1'b1;
                    else                win_shift   = 1'b1;
                end else if (rise_p1) begin
                    glitch_n = 1'b1;
                end else if (count == TIMEOUT) begin
                    state_n = STOPPED;
                    count_n = '0;
                    // Only a running meter reports the stop; an armed one just disarms
                    if (state == RUNNING) begin
                        per_n       = SAT_TO;
                        per_vld_n   = 1'b1;
                        win_preload = 1'b1;
                        win_sample  = SAT_TO;
                    end
                end
            end
            default: begin
                state_n = STOPPED;
                count_n = '0;
            end
        endcase
    end

    // ---- stage p2: FSM, counter and period outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STOPPED;
            count       <= '0;
            cadence_per <= SAT_TO;
            per_vld     <= 1'b0;
            glitch      <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            cadence_per <= per_n;
            per_vld     <= per_vld_n;
            glitch      <= glitch_n;
        end
    end

    assign not_pedaling = (state == STOPPED);

    cadence_avg_window #(
        .PER_W    (PER_W),
        .AVG_LOG2 (AVG_LOG2),
        .RST_VAL  (SAT_TO)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .preload (win_preload),
        .shift   (win_shift),
        .sample  (win_sample),
        .avg     (cadence_avg)
    );

endmodule

// File: tb/tb_cadence_period_avg.sv
// Scoreboard bench for cadence_period_avg: a timestamp-based reference model
// predicts each per_vld/glitch event; a monitor checks what the DUT presents.
module tb_cadence_period_avg;

    localparam int TO      = 16'h0800;
    localparam int MINP    = 16'h0010;
    localparam int WIN     = 4;
    localparam int SAT_TO  = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cadence_filt = 1'b0;
    logic [7:0] cadence_per, cadence_avg;
    logic       per_vld, not_pedaling, glitch;

    cadence_period_avg #(
        .CNT_W     (16),
        .PER_W     (8),
        .SLICE_LSB (4),
        .TIMEOUT   (16'h0800),
        .MIN_PER   (16'h0010),
        .AVG_LOG2  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cadence_filt (cadence_filt),
        .cadence_per  (cadence_per),
        .cadence_avg  (cadence_avg),
        .per_vld      (per_vld),
        .not_pedaling (not_pedaling),
        .glitch       (glitch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   edge_n;
        int   per;
        int   avg;
        bit   np;
    } exp_t;

    exp_t exp_q[$];
    int   glitch_q[$];
    int   edge_cnt   = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    bit   exp_np     = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: timestamps, a queue window and plain arithmetic
    localparam int M_STOP = 0, M_ARMED = 1, M_RUN = 2;
    int mstate = M_STOP;
    int last_t = 0;
    int win[$];
    bit s1 = 1'b0, s2 = 1'b0;

    function automatic int sat(input int c);
        int v;
        v = c / 16;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int win_avg();
        int s;
        s = 0;
        foreach (win[i]) s += win[i];
        return s / WIN;
    endfunction

    task automatic fill_win(input int v);
        win.delete();
        for (int i = 0; i < WIN; i++) win.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    task automatic push_vld(input int n, input int p);
        exp_t e;
        e.edge_n = n;
        e.per    = p;
        e.avg    = win_avg();
        e.np     = (mstate == M_STOP);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit v);
        int  n, cnt, p;
        bit  rise;
        @(negedge clk);
        cadence_filt = v;
        n    = edge_cnt + 1;
        rise = s1 && !s2;
        s2   = s1;
        s1   = v;
        cnt  = n - last_t;
        if (cnt > TO) cnt = TO;
        if (mstate == M_STOP) begin
            if (rise) begin
                mstate = M_ARMED;
                last_t = n;
            end
        end else if (rise) begin
            if (cnt >= MINP) begin
                p = sat(cnt);
                if (mstate == M_ARMED) fill_win(p);
                else begin
                    win.push_front(p);
                    void'(win.pop_back());
                end
                mstate = M_RUN;
                last_t = n;
                push_vld(n, p);
            end else begin
                glitch_q.push_back(n);
            end
        end else if (cnt == TO) begin
            if (mstate == M_RUN) begin
                fill_win(SAT_TO);
                mstate = M_STOP;
                push_vld(n, SAT_TO);
            end
            mstate = M_STOP;
        end
        exp_np = (mstate == M_STOP);
    endtask

    task automatic pulse(input int period, input int high);
        for (int i = 0; i < period; i++) step(i < high);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst          = 1'b1;
        cadence_filt = 1'b0;
        mstate       = M_STOP;
        fill_win(SAT_TO);
        s1           = 1'b0;
        s2           = 1'b0;
        exp_np       = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_per",   cadence_per,  SAT_TO);
        chk("rst_avg",   cadence_avg,  SAT_TO);
        chk("rst_np",    not_pedaling, 1);
        chk("rst_vld",   per_vld,      0);
        chk("rst_glitch", glitch,      0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: checks every presented event against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("not_pedaling", not_pedaling, exp_np);
                if (per_vld) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_per_vld", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("vld_edge", edge_cnt, e.edge_n);
                        chk("cadence_per", cadence_per, e.per);
                        chk("cadence_avg", cadence_avg, e.avg);
                        chk("np_at_vld", not_pedaling, e.np);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].edge_n <= edge_cnt) begin
                    e = exp_q.pop_front();
                    chk("missing_per_vld", 0, 1);
                end
                if (glitch) begin
                    if (glitch_q.size() == 0) chk("unexpected_glitch", 1, 0);
                    else chk("glitch_edge", edge_cnt, glitch_q.pop_front());
                end else if (glitch_q.size() != 0 && glitch_q[0] <= edge_cnt) begin
                    void'(glitch_q.pop_front());
                    chk("missing_glitch", 0, 1);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int per, hi;
        fill_win(SAT_TO);
        do_reset(2);
        repeat (5) step(1'b0);

        pulse(256, 4);          // arms, no period
        pulse(256, 4);          // per = avg = 10
        pulse(512, 4);          // per 20, avg 14
        pulse(512, 4);          // per 20, avg 18
        pulse(8, 4);            // glitch
        pulse(248, 4);          // per 10, measured from the last valid rise
        pulse(TO + 20, 4);      // timeout while running
        pulse(300, 4);          // re-arm, no period
        pulse(TO, 4);           // next rise lands exactly on the timeout count
        pulse(300, 4);          // capture of saturated period
        pulse(300, 4);
        pulse(50, 4);
        do_reset(1);            // reset while running
        repeat (3) step(1'b0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) per = $urandom_range(TO - 8, TO + 8);
            else                           per = $urandom_range(3, 600);
            hi = $urandom_range(1, per - 1);
            pulse(per, hi);
        end
        repeat (TO + 40) step(1'b0);

        chk("sb_vld_drain",    exp_q.size(),    0);
        chk("sb_glitch_drain", glitch_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
